rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 25 ++
 rtl/rf_arb_slot.sv | 56 +++++
 rtl/rf_write_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter: widths, requester
// count, grant encoding and a one-hot helper for register addresses.
// Optional scoreboard feature: RF_ARB_SCOREBOARD_EN.
package rf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REQ    = 2;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_0    = 2'd1,
        GNT_1    = 2'd2
    } gnt_e;

    // One-hot vector with the bit for register address a set.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_arb_slot.sv
// One-entry holding slot for a single write requester. Ready is simply
// "empty" (never a function of valid), so a slot drained at an edge can take
// a new write no earlier than the following edge.
module rf_arb_slot
    import rf_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] reg_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  clear_i,
    output logic                  ready_o,
    output logic                  full_o,
    output logic [REG_ADDR_W-1:0] reg_o,
    output logic [DATA_W-1:0]     data_o
);

    logic                  full_q, full_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     data_q, data_d;

    // Held low while reset is asserted so nothing is accepted during reset.
    assign ready_o = ~full_q & ~reset;
    assign full_o  = full_q;
    assign reg_o   = reg_q;
    assign data_o  = data_q;

    // Next-state: drain on grant, otherwise capture an accepted write.
    always_comb begin
        full_d = full_q;
        reg_d  = reg_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (valid_i && ready_o) begin
            full_d = 1'b1;
            reg_d  = reg_i;
            data_d = data_i;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter. Each requester owns a one-entry
// slot; one full slot is granted per cycle (round-robin or fixed priority)
// and drives a registered write strobe. Writes to register 0 are drained
// silently. Define RF_ARB_SCOREBOARD_EN to add the pending-register
// scoreboard and read-hazard outputs.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] req0_reg,
    input  logic [REG_ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0]     req0_data,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData
`ifdef RF_ARB_SCOREBOARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] readRegA,
    input  logic [REG_ADDR_W-1:0] readRegB,
    output logic                  hazardA,
    output logic                  hazardB,
    output logic [NUM_REGS-1:0]   pending
`endif
);

    logic [NUM_REQ-1:0]    valid_w, ready_w, full_w, clear_w;
    logic [REG_ADDR_W-1:0] reg_in_w  [NUM_REQ];
    logic [DATA_W-1:0]     data_in_w [NUM_REQ];
    logic [REG_ADDR_W-1:0] reg_w     [NUM_REQ];
    logic [DATA_W-1:0]     data_w    [NUM_REQ];

    assign valid_w      = {req1_valid, req0_valid};
    assign reg_in_w[0]  = req0_reg;
    assign reg_in_w[1]  = req1_reg;
    assign data_in_w[0] = req0_data;
    assign data_in_w[1] = req1_data;
    assign req0_ready   = ready_w[0];
    assign req1_ready   = ready_w[1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            rf_arb_slot u_slot (
                .clk     (clk),
                .reset   (reset),
                .valid_i (valid_w[gi]),
                .reg_i   (reg_in_w[gi]),
                .data_i  (data_in_w[gi]),
                .clear_i (clear_w[gi]),
                .ready_o (ready_w[gi]),
                .full_o  (full_w[gi]),
                .reg_o   (reg_w[gi]),
                .data_o  (data_w[gi])
            );
        end
    endgenerate

    // last_grant_q = 1 means requester 1 was granted most recently.
    logic                  last_grant_q, last_grant_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    gnt_e                  gnt;
    logic [REG_ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0]     sel_data;

    // Grant selection: contention resolved by priority mode, else the lone full slot.
    always_comb begin
        gnt = GNT_NONE;
        if (full_w[0] && full_w[1]) begin
            gnt = (PRIO_FIXED || last_grant_q) ? GNT_0 : GNT_1;
        end else if (full_w[0]) begin
            gnt = GNT_0;
        end else if (full_w[1]) begin
            gnt = GNT_1;
        end
    end

    assign clear_w  = {gnt == GNT_1, gnt == GNT_0};
    assign sel_reg  = (gnt == GNT_1) ? reg_w[1]  : reg_w[0];
    assign sel_data = (gnt == GNT_1) ? data_w[1] : data_w[0];

    // Output next-state: strobe only for granted non-zero destinations; hold otherwise.
    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        last_grant_d = last_grant_q;
        if (gnt != GNT_NONE) begin
            last_grant_d = (gnt == GNT_1);
            if (sel_reg != '0) begin
                reg_write_d  = 1'b1;
                write_reg_d  = sel_reg;
                write_data_d = sel_data;
            end
        end
    end

    // Output and arbitration-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            last_grant_q <= 1'b1;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;

`ifdef RF_ARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending_w;

    // Registers with a write still buffered or currently being strobed; $zero never pending.
    always_comb begin
        pending_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full_w[i]) begin
                pending_w = pending_w | reg_onehot(reg_w[i]);
            end
        end
        if (reg_write_q) begin
            pending_w = pending_w | reg_onehot(write_reg_q);
        end
        pending_w[0] = 1'b0;
    end

    assign pending = pending_w;
    assign hazardA = pending_w[readRegA];
    assign hazardB = pending_w[readRegB];
`endif

endmodule
